// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Explicit wrap so non-power-of-two depths need no masking.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

  function automatic bit params_ok(input int width, input int depth, input int fwft);
    return (width >= 1) && (depth >= 2) && ((fwft == 0) || (fwft == 1));
  endfunction

endpackage

// File: rtl/fifo_sync_prog_if.sv
// Handshake, threshold and status bundle between a FIFO and its user.
interface fifo_sync_prog_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [CW-1:0]    af_thresh;
  logic [CW-1:0]    ae_thresh;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;
  logic [CW-1:0]    data_count;

  modport master (
    output din, wr_en, rd_en, af_thresh, ae_thresh,
    input  dout, valid, full, empty, almost_full, almost_empty,
           overflow, underflow, data_count
  );

  modport slave (
    input  din, wr_en, rd_en, af_thresh, ae_thresh,
    output dout, valid, full, empty, almost_full, almost_empty,
           overflow, underflow, data_count
  );
endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port WIDTH x DEPTH storage; read port is combinational or registered by mode.
module fifo_sdp_ram
  import fifo_pkg::*;
#(
  parameter int         WIDTH = 8,
  parameter int         DEPTH = 16,
  parameter fifo_mode_e MODE  = FIFO_FWFT,
  parameter int         AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  if (MODE == FIFO_FWFT) begin : g_async_rd
    logic unused_rd;
    assign unused_rd = re_i ^ rst_n;
    assign rdata_o   = mem_q[raddr_i];
  end else begin : g_reg_rd
    logic [WIDTH-1:0] rdata_q;
    // Output register resets to zero and holds between accepted reads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
    end
    assign rdata_o = rdata_q;
  end

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with FWFT/standard read, any depth, programmable flags and error pulses.
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int FWFT  = 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic            clk,
  input logic            arst_n,
  fifo_sync_prog_if.slave bus
);

  localparam int         AW   = $clog2(DEPTH);
  localparam fifo_mode_e MODE = (FWFT == 1) ? FIFO_FWFT : FIFO_STD;

  if (!params_ok(WIDTH, DEPTH, FWFT)) begin : g_param_err
    $error("fifo_sync_prog: need WIDTH>=1, DEPTH>=2, FWFT in {0,1}");
  end

  logic [1:0]    rst_sync_q;
  logic          run;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, udf_q, vld_q;
  logic          full, empty, wr_acc, rd_acc;

  assign run    = rst_sync_q[1];
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = run && bus.wr_en && !full;
  assign rd_acc = run && bus.rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_acc ? AW'(ptr_inc(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
    rd_ptr_d = rd_acc ? AW'(ptr_inc(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Release is retimed through two flops; requests are ignored until run rises.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rst_sync_q <= 2'b00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= run && bus.wr_en && full;
      udf_q      <= run && bus.rd_en && empty;
      vld_q      <= rd_acc;
    end
  end

  fifo_sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .MODE  (MODE),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (arst_n),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.din),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.dout)
  );

  assign bus.valid        = (MODE == FIFO_FWFT) ? !empty : vld_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= bus.af_thresh);
  assign bus.almost_empty = (count_q <= bus.ae_thresh);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
  assign bus.data_count   = count_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: FWFT vector table, random traffic against a queue model, standard-mode/reset sequence.
module tb_fifo_sync_prog;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst_f_n, arst_s_n;

  fifo_sync_prog_if #(.WIDTH(W), .DEPTH(D)) ff ();
  fifo_sync_prog_if #(.WIDTH(W), .DEPTH(D)) fs ();

  fifo_sync_prog #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
    .clk(clk), .arst_n(arst_f_n), .bus(ff)
  );
  fifo_sync_prog #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
    .clk(clk), .arst_n(arst_s_n), .bus(fs)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flag rules expressed straight from occupancy and thresholds.
  task automatic chk_fwft(input string tag, input int cnt, input int af, input int ae);
    chk({tag, " count"},  32'(ff.data_count),   32'(cnt));
    chk({tag, " empty"},  32'(ff.empty),        32'(cnt == 0));
    chk({tag, " full"},   32'(ff.full),         32'(cnt == D));
    chk({tag, " afull"},  32'(ff.almost_full),  32'(cnt >= af));
    chk({tag, " aempty"}, 32'(ff.almost_empty), 32'(cnt <= ae));
    chk({tag, " valid"},  32'(ff.valid),        32'(cnt != 0));
  endtask

  task automatic step_f(input logic wr, input logic rd, input logic [7:0] din);
    ff.wr_en = wr; ff.rd_en = rd; ff.din = din;
    @(posedge clk); #1;
  endtask

  task automatic step_s(input logic wr, input logic rd, input logic [7:0] din);
    fs.wr_en = wr; fs.rd_en = rd; fs.din = din;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    int         af;
    int         ae;
    int         cnt;
    logic [7:0] dout;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [7:0] din,
                              input int af, input int ae, input int cnt,
                              input logic [7:0] dout, input logic ovf, input logic udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = din; v.af = af; v.ae = ae;
    v.cnt = cnt; v.dout = dout; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  logic [7:0] q_m[$];

  initial begin
    string tag;
    int pw, pr, af_r, ae_r, sz;
    logic wr, rd, e_ovf, e_udf;

    // wr rd din af ae | cnt dout ovf udf
    vt.push_back(mk(1, 0, 8'hA1, 4, 1, 1, 8'hA1, 0, 0));
    vt.push_back(mk(0, 1, 8'h00, 4, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(0, 1, 8'h00, 4, 1, 0, 8'h00, 0, 1));
    vt.push_back(mk(0, 0, 8'h00, 4, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 1, 8'h77, 4, 1, 1, 8'h77, 0, 1));
    vt.push_back(mk(0, 1, 8'h00, 4, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 8'h01, 4, 1, 1, 8'h01, 0, 0));
    vt.push_back(mk(1, 0, 8'h02, 4, 1, 2, 8'h01, 0, 0));
    vt.push_back(mk(1, 0, 8'h03, 4, 1, 3, 8'h01, 0, 0));
    vt.push_back(mk(1, 0, 8'h04, 4, 1, 4, 8'h01, 0, 0));
    vt.push_back(mk(1, 0, 8'h05, 4, 1, 5, 8'h01, 0, 0));
    vt.push_back(mk(1, 0, 8'h06, 4, 1, 5, 8'h01, 1, 0));
    vt.push_back(mk(0, 0, 8'h00, 4, 1, 5, 8'h01, 0, 0));
    vt.push_back(mk(0, 1, 8'h00, 4, 1, 4, 8'h02, 0, 0));
    vt.push_back(mk(0, 1, 8'h00, 4, 1, 3, 8'h03, 0, 0));
    vt.push_back(mk(0, 1, 8'h00, 4, 1, 2, 8'h04, 0, 0));
    vt.push_back(mk(1, 0, 8'h07, 4, 1, 3, 8'h04, 0, 0));
    vt.push_back(mk(1, 0, 8'h08, 4, 1, 4, 8'h04, 0, 0));
    vt.push_back(mk(1, 0, 8'h09, 4, 1, 5, 8'h04, 0, 0));
    vt.push_back(mk(1, 1, 8'h0A, 4, 1, 4, 8'h05, 1, 0));
    vt.push_back(mk(0, 1, 8'h00, 4, 1, 3, 8'h07, 0, 0));
    vt.push_back(mk(0, 1, 8'h00, 4, 1, 2, 8'h08, 0, 0));
    vt.push_back(mk(1, 1, 8'h10, 4, 1, 2, 8'h09, 0, 0));
    vt.push_back(mk(1, 1, 8'h11, 4, 1, 2, 8'h10, 0, 0));
    vt.push_back(mk(1, 1, 8'h12, 4, 1, 2, 8'h11, 0, 0));
    vt.push_back(mk(1, 1, 8'h13, 4, 1, 2, 8'h12, 0, 0));
    vt.push_back(mk(0, 1, 8'h00, 4, 1, 1, 8'h13, 0, 0));
    vt.push_back(mk(0, 1, 8'h00, 4, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0));
    vt.push_back(mk(1, 0, 8'h20, 0, 5, 1, 8'h20, 0, 0));
    vt.push_back(mk(0, 1, 8'h00, 4, 1, 0, 8'h00, 0, 0));

    ff.wr_en = 0; ff.rd_en = 0; ff.din = '0; ff.af_thresh = 3'd4; ff.ae_thresh = 3'd1;
    fs.wr_en = 0; fs.rd_en = 0; fs.din = '0; fs.af_thresh = 3'd4; fs.ae_thresh = 3'd1;
    arst_f_n = 1'b0;
    arst_s_n = 1'b0;
    #22;

    // Held in reset across edges.
    chk_fwft("reset", 0, 4, 1);
    chk("reset ovf",      32'(ff.overflow),  32'd0);
    chk("reset udf",      32'(ff.underflow), 32'd0);
    chk("reset std valid", 32'(fs.valid),    32'd0);
    chk("reset std dout",  32'(fs.dout),     32'd0);
    ff.af_thresh = 3'd0;
    #1;
    chk("reset afull@af0", 32'(ff.almost_full), 32'd1);
    ff.af_thresh = 3'd4;

    @(posedge clk); #1;
    arst_f_n = 1'b1;
    arst_s_n = 1'b1;
    step_f(0, 0, 8'h00);
    step_f(0, 0, 8'h00);

    for (int i = 0; i < vt.size(); i++) begin
      ff.af_thresh = CW'(vt[i].af);
      ff.ae_thresh = CW'(vt[i].ae);
      step_f(vt[i].wr, vt[i].rd, vt[i].din);
      tag = $sformatf("row%0d", i);
      chk_fwft(tag, vt[i].cnt, vt[i].af, vt[i].ae);
      chk({tag, " ovf"}, 32'(ff.overflow),  32'(vt[i].ovf));
      chk({tag, " udf"}, 32'(ff.underflow), 32'(vt[i].udf));
      if (vt[i].cnt != 0) chk({tag, " dout"}, 32'(ff.dout), 32'(vt[i].dout));
    end

    // Random traffic; FIFO is empty here.
    q_m.delete();
    af_r = 4; ae_r = 1;
    for (int c = 0; c < 400; c++) begin
      if (c % 64 == 0) begin
        af_r = $urandom_range(0, 7);
        ae_r = $urandom_range(0, 7);
      end
      case ((c / 100) % 4)
        0:       begin pw = 75; pr = 30; end
        1:       begin pw = 30; pr = 75; end
        2:       begin pw = 60; pr = 60; end
        default: begin pw = 90; pr = 90; end
      endcase
      wr = ($urandom_range(0, 99) < pw);
      rd = ($urandom_range(0, 99) < pr);
      ff.af_thresh = CW'(af_r);
      ff.ae_thresh = CW'(ae_r);
      sz    = q_m.size();
      e_ovf = wr && (sz == D);
      e_udf = rd && (sz == 0);
      if (rd && sz > 0) void'(q_m.pop_front());
      step_f(wr, rd, 8'($urandom));
      if (wr && sz < D) q_m.push_back(ff.din);
      tag = $sformatf("rnd%0d", c);
      chk_fwft(tag, q_m.size(), af_r, ae_r);
      chk({tag, " ovf"}, 32'(ff.overflow),  32'(e_ovf));
      chk({tag, " udf"}, 32'(ff.underflow), 32'(e_udf));
      if (q_m.size() != 0) chk({tag, " dout"}, 32'(ff.dout), 32'(q_m[0]));
    end
    step_f(0, 0, 8'h00);

    // Standard read mode: one-cycle latency, valid for exactly one cycle.
    step_s(1, 0, 8'h3C);
    chk("std wr count", 32'(fs.data_count), 32'd1);
    chk("std wr valid", 32'(fs.valid),      32'd0);
    step_s(0, 1, 8'h00);
    chk("std rd dout",  32'(fs.dout),       32'h3C);
    chk("std rd valid", 32'(fs.valid),      32'd1);
    chk("std rd count", 32'(fs.data_count), 32'd0);
    step_s(0, 0, 8'h00);
    chk("std hold valid", 32'(fs.valid), 32'd0);
    chk("std hold dout",  32'(fs.dout),  32'h3C);
    step_s(0, 1, 8'h00);
    chk("std udf",       32'(fs.underflow), 32'd1);
    chk("std udf valid", 32'(fs.valid),     32'd0);
    step_s(1, 0, 8'h11);
    step_s(1, 0, 8'h22);
    step_s(1, 0, 8'h33);
    chk("std count3", 32'(fs.data_count), 32'd3);

    // Asynchronous reset mid-cycle.
    fs.wr_en = 0;
    arst_s_n = 1'b0;
    #2;
    chk("arst count",  32'(fs.data_count),   32'd0);
    chk("arst empty",  32'(fs.empty),        32'd1);
    chk("arst full",   32'(fs.full),         32'd0);
    chk("arst aempty", 32'(fs.almost_empty), 32'd1);
    chk("arst afull",  32'(fs.almost_full),  32'd0);
    chk("arst valid",  32'(fs.valid),        32'd0);
    chk("arst dout",   32'(fs.dout),         32'd0);
    @(posedge clk); #1;
    arst_s_n = 1'b1;
    step_s(1, 0, 8'h55);
    chk("sync edge1 count", 32'(fs.data_count), 32'd0);
    step_s(1, 0, 8'h55);
    chk("sync edge2 count", 32'(fs.data_count), 32'd0);
    step_s(1, 0, 8'h44);
    chk("sync edge3 count", 32'(fs.data_count), 32'd1);
    step_s(0, 1, 8'h00);
    chk("post rst dout",  32'(fs.dout),  32'h44);
    chk("post rst valid", 32'(fs.valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_sync_prog.md
Name: fifo_sync_prog

Overview:
- Second-generation single-clock FIFO for datapath buffering between streaming stages.
- Selectable read mode: first-word-fall-through (FWFT) or standard registered read.
- Supports any DEPTH, including non-power-of-two, with a correctly sized occupancy count.
- Adds programmable almost-full/almost-empty thresholds and overflow/underflow error pulses.

Parameters:
- WIDTH, 8: data word width in bits, must be >= 1.
- DEPTH, 16: number of storage entries, any value >= 2.
- FWFT, 1: 1 = first-word-fall-through read, 0 = standard read with one-cycle latency.
- CW, $clog2(DEPTH+1): derived count width; never overridden.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- arst_n  in  1  reset, asynchronous assert, active-low.
- din  in  WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read/pop request.
- af_thresh  in  CW  almost-full threshold, quasi-static.
- ae_thresh  in  CW  almost-empty threshold, quasi-static.
- dout  out  WIDTH  read data.
- valid  out  1  dout holds a valid word (meaning depends on mode, see Behaviour).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= af_thresh.
- almost_empty  out  1  count <= ae_thresh.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.
- data_count  out  CW  current occupancy, range 0..DEPTH.

Behaviour:
- Reset (arst_n low, asynchronous): wr_ptr, rd_ptr and count go to 0; dout = 0; standard-mode valid = 0; overflow = 0; underflow = 0. Storage contents are not reset.
- Outputs while in reset: empty = 1, full = 0, almost_empty = 1, almost_full = (af_thresh == 0).
- Reset release is synchronised internally with a 2-flop chain. No write or read is accepted until the synchronised release.
- Pointers run 0..DEPTH-1 and wrap to 0 explicitly. No power-of-two masking.
- count is a separate CW-bit register. data_count = count.
- full, empty, almost_full and almost_empty are combinational from count. They are not registered.
- Write accept: wr_en && !full, evaluated on pre-edge state. On accept, mem[wr_ptr] <= din and wr_ptr advances.
- Read accept: rd_en && !empty, evaluated on pre-edge state. On accept, rd_ptr advances.
- Simultaneous accepted read and write leave count unchanged.
- Write while full is rejected, even if a read is accepted in the same cycle (no pass-through). overflow pulses high for one cycle on the next edge.
- Read while empty is rejected. underflow pulses high for one cycle on the next edge. In FWFT mode, a write to an empty FIFO in the same cycle does not rescue the read.
- Rejected requests change no state other than the error pulse.
- FWFT mode:
  - dout = mem[rd_ptr] via asynchronous read; valid = !empty.
  - A word written at edge k is on dout with valid = 1 immediately after edge k.
  - rd_en acts as acknowledge/pop of the word currently shown.
- Standard mode:
  - An accepted read at edge k registers mem[rd_ptr] into dout, and valid = 1 for exactly the cycle after edge k.
  - dout holds its last value otherwise.
- Threshold changes take effect combinationally. af_thresh = 0 forces almost_full = 1. ae_thresh >= DEPTH forces almost_empty = 1.
- Elaboration error if DEPTH < 2, WIDTH < 1, or FWFT not in {0,1}.

Decomposition:
- Package fifo_pkg holds:
  - function ptr_inc(ptr, depth), the explicit wrap increment;
  - typedef fifo_mode_e {FIFO_STD = 0, FIFO_FWFT = 1};
  - a parameter-check macro or function.
- Sub-module fifo_sdp_ram holds storage:
  - simple dual-port, WIDTH x DEPTH;
  - synchronous write;
  - asynchronous read port for FWFT, registered read port for standard mode, selected by generate.
- Control logic (pointers, count, flags, error pulses) stays in fifo_sync_prog.

Test Plan (WIDTH=8, DEPTH=5 unless stated):
1. Reset/FWFT basic: after release, write 0xA1 at edge k -> after edge k: valid=1, dout=0xA1, data_count=1, empty=0. Assert rd_en for 1 cycle -> empty=1, valid=0.
2. Fill/overflow/wrap: write 0x01..0x05 -> full=1, data_count=5. Write 0x06 -> overflow pulses 1 cycle, count stays 5. Drain and refill 3 cycles -> words return in order across the pointer wrap (rd_ptr 4->0), no 0x06 ever read.
3. Simultaneous ops: count=2, wr_en=rd_en=1 for 4 cycles with 0x10..0x13 -> count stays 2, outputs in FIFO order. At full, both asserted -> read accepted, write rejected, overflow=1, count=4.
4. Underflow: empty, rd_en=1 -> underflow pulses 1 cycle, pointers unchanged. rd_en+wr_en while empty -> underflow=1, count=1.
5. Thresholds: af_thresh=4, ae_thresh=1. Counts 0..5 -> almost_empty=1 only at counts 0,1; almost_full=1 at counts 4,5. af_thresh=0 -> almost_full=1 at count 0.
6. Standard mode (FWFT=0) plus async reset: write 0x3C, rd_en at edge k -> dout=0x3C, valid=1 for exactly one cycle. Drop arst_n mid-cycle with count=3 -> flags and count are reset before the next edge, and no accept occurs for 2 edges after release.
